button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 26 ++
 rtl/button_conditioner_if.sv | 11 +
 rtl/btn_channel.sv | 97 +++++++++
 rtl/button_conditioner.sv | 55 +++++
 tb/tb_button_conditioner.sv | 128 ++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared UI constants for the button conditioner: default timings, channel
// state encodings and the counter-width helper.
package button_conditioner_pkg;

    localparam int NUM_BUTTONS        = 4;
    localparam int DEF_DEB_CYCLES     = 500000;    // 10 ms at 50 MHz
    localparam int DEF_REP_DELAY      = 25000000;
    localparam int DEF_REP_PERIOD     = 5000000;
    localparam logic [3:0] DEF_REP_MASK = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_t;

    // One width covers every counter; it only ever has to reach (max - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw button levels in, press events and held levels out.
interface button_conditioner_if;
    import button_conditioner_pkg::*;

    logic [NUM_BUTTONS-1:0] Button;
    logic [NUM_BUTTONS-1:0] BP;
    logic [NUM_BUTTONS-1:0] held;

    modport master (output Button, input BP, input held);
    modport slave  (input Button, output BP, output held);
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, counter debouncer and press/auto-repeat FSM.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter bit REP_EN     = 1'b0,
    parameter int CW         = cnt_width(DEF_DEB_CYCLES, DEF_REP_DELAY, DEF_REP_PERIOD)
) (
    input  logic clk,
    input  logic srst,
    input  logic button,
    output logic req,
    output logic d
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REP_PERIOD - 1);

    logic          sync1_reg, s_reg, d_reg;
    logic [CW-1:0] dcnt_reg, rcnt_reg, rcnt_next;
    chan_state_t   state_reg, state_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
            d_reg     <= 1'b0;
            dcnt_reg  <= '0;
            rcnt_reg  <= '0;
            state_reg <= IDLE;
        end else begin
            sync1_reg <= button;
            s_reg     <= sync1_reg;
            // Any return to the current level restarts the stability count.
            if (s_reg == d_reg) begin
                dcnt_reg <= '0;
            end else if (dcnt_reg == DEB_LAST) begin
                d_reg    <= s_reg;
                dcnt_reg <= '0;
            end else begin
                dcnt_reg <= dcnt_reg + 1'b1;
            end
            rcnt_reg  <= rcnt_next;
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        req        = 1'b0;
        case (state_reg)
            IDLE: begin
                rcnt_next = '0;
                if (d_reg) begin
                    req        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!d_reg) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (REP_EN) begin
                    if (rcnt_reg == DLY_LAST) begin
                        req        = 1'b1;
                        rcnt_next  = '0;
                        state_next = REPEAT;
                    end else begin
                        rcnt_next = rcnt_reg + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!d_reg) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt_reg == PER_LAST) begin
                    req       = 1'b1;
                    rcnt_next = '0;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

    assign d = d_reg;

endmodule

// File: rtl/button_conditioner.sv
// Four conditioned buttons feeding a lowest-index-wins arbiter; losing
// requests are simply dropped so BP is never more than one-hot.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int         DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int         REP_DELAY  = DEF_REP_DELAY,
    parameter int         REP_PERIOD = DEF_REP_PERIOD,
    parameter logic [3:0] REP_MASK   = DEF_REP_MASK
) (
    input  logic               clk,
    input  logic               rst,
    button_conditioner_if.slave bus
);

    localparam int CW = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);

    logic [NUM_BUTTONS-1:0] req, d, grant;
    logic [NUM_BUTTONS-1:0] bp_reg, held_reg;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
            btn_channel #(
                .DEB_CYCLES (DEB_CYCLES),
                .REP_DELAY  (REP_DELAY),
                .REP_PERIOD (REP_PERIOD),
                .REP_EN     (REP_MASK[gi]),
                .CW         (CW)
            ) u_chan (
                .clk    (clk),
                .srst   (rst),
                .button (bus.Button[gi]),
                .req    (req[gi]),
                .d      (d[gi])
            );
        end
    endgenerate

    // Isolate the lowest set bit.
    assign grant = req & (~req + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_reg   <= '0;
            held_reg <= '0;
        end else begin
            bp_reg   <= grant;
            held_reg <= d;
        end
    end

    assign bus.BP   = bp_reg;
    assign bus.held = held_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timings
// (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, REP_MASK=1100).
module tb_button_conditioner;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEB_CYCLES (4),
        .REP_DELAY  (10),
        .REP_PERIOD (3),
        .REP_MASK   (4'b1100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input int e,
                          input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s edge %0d observed=%b expected=%b", tag, e, obs, exp_v);
        end
    endtask

    initial begin
        logic [3:0] exp_bp;
        logic [3:0] exp_held;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.Button = 4'b0000;

        // Reset state
        for (int e = 1; e <= 3; e++) begin
            tick();
            check4("reset_bp", e, bus.BP, 4'b0000);
            check4("reset_held", e, bus.held, 4'b0000);
        end
        rst = 1'b0;
        tick();

        // Basic press on button 0: single pulse at edge 7, no repeat
        bus.Button = 4'b0001;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp_bp   = (e == 7) ? 4'b0001 : 4'b0000;
            exp_held = (e >= 7) ? 4'b0001 : 4'b0000;
            check4("basic_bp", e, bus.BP, exp_bp);
            check4("basic_held", e, bus.held, exp_held);
        end
        bus.Button = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_held = (e < 7) ? 4'b0001 : 4'b0000;
            check4("basic_rel_bp", e, bus.BP, 4'b0000);
            check4("basic_rel_held", e, bus.held, exp_held);
        end

        // Bounce on button 1: 2-cycle toggles for 20 cycles, final rise at edge 21
        for (int e = 1; e <= 40; e++) begin
            bus.Button = (e <= 20) ? {2'b00, (((e - 1) / 2) % 2 == 0), 1'b0} : 4'b0010;
            tick();
            exp_bp   = (e == 27) ? 4'b0010 : 4'b0000;
            exp_held = (e >= 27) ? 4'b0010 : 4'b0000;
            check4("bounce_bp", e, bus.BP, exp_bp);
            check4("bounce_held", e, bus.held, exp_held);
        end
        bus.Button = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_held = (e < 7) ? 4'b0010 : 4'b0000;
            check4("bounce_rel_bp", e, bus.BP, 4'b0000);
            check4("bounce_rel_held", e, bus.held, exp_held);
        end

        // Auto-repeat on button 2: held for edges 1..40
        for (int e = 1; e <= 55; e++) begin
            bus.Button = (e <= 40) ? 4'b0100 : 4'b0000;
            tick();
            exp_bp   = (e inside {7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44}) ? 4'b0100 : 4'b0000;
            exp_held = (e >= 7 && e <= 46) ? 4'b0100 : 4'b0000;
            check4("repeat_bp", e, bus.BP, exp_bp);
            check4("repeat_held", e, bus.held, exp_held);
        end

        // Simultaneous press of buttons 0 and 3: only bit 0 wins
        for (int e = 1; e <= 24; e++) begin
            bus.Button = (e <= 8) ? 4'b1001 : 4'b0000;
            tick();
            exp_bp   = (e == 7) ? 4'b0001 : 4'b0000;
            exp_held = (e >= 7 && e <= 14) ? 4'b1001 : 4'b0000;
            check4("simul_bp", e, bus.BP, exp_bp);
            check4("simul_held", e, bus.held, exp_held);
        end

        // Reset at edges 19..20 while button 3 repeats
        for (int e = 1; e <= 60; e++) begin
            bus.Button = (e <= 45) ? 4'b1000 : 4'b0000;
            rst = (e == 19 || e == 20);
            tick();
            exp_bp   = (e inside {7, 17, 27, 37, 40, 43, 46, 49}) ? 4'b1000 : 4'b0000;
            exp_held = ((e >= 7 && e <= 18) || (e >= 27 && e <= 51)) ? 4'b1000 : 4'b0000;
            check4("rstmid_bp", e, bus.BP, exp_bp);
            check4("rstmid_held", e, bus.held, exp_held);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
